clut_thresh_ctrl: RTL

//  Frame sequencer for the clutter-map 3x3 max-threshold pipeline (clutter_map/thresh_top).
//  Per CPI it reads the clutter-map RAM as NUM_LINES back-to-back lines of LINE_LEN bins.
//  It generates the RAM read enable/address and the latency-aligned radmap_rd_vld.
//  It owns the clut_cpi counter and counts thresh_valid beats to close each frame.
//  The threshold pipeline aligns rows with fixed LINE_LEN-cycle delays, so the reads in a frame carry no gaps.

---
 rtl/clut_pkg.sv | 20 ++
 rtl/clut_thresh_ctrl_if.sv | 29 ++
 rtl/clut_vld_delay.sv | 21 ++
 rtl/clut_thresh_ctrl.sv | 117 +++++++++++
 4 files changed

// File: rtl/clut_pkg.sv
// rtl/clut_pkg.sv - shared types and sizing helpers for the clutter-map frame sequencer
package clut_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_RDY,
        ST_READ,
        ST_DRAIN,
        ST_DONE
    } clut_state_t;

    localparam int CLUT_LINE_LEN = 32;
    localparam int CLUT_NUM_CPI  = 120;

    // Wide enough to hold a full frame's beat count, including the terminal value.
    function automatic int beat_w(input int line_len, input int num_lines);
        return $clog2(line_len * num_lines + 1);
    endfunction

endpackage

// File: rtl/clut_thresh_ctrl_if.sv
// rtl/clut_thresh_ctrl_if.sv - control/status bundle between the frame sequencer and its neighbours
interface clut_thresh_ctrl_if #(
    parameter int ADDR_W = 11
);
    logic              frame_start;
    logic              map_rdy;
    logic              abort;
    logic              thresh_valid;
    logic              ram_rd_en;
    logic [ADDR_W-1:0] ram_rd_addr;
    logic              radmap_rd_vld;
    logic [15:0]       clut_cpi;
    logic              busy;
    logic              frame_done;
    logic              err_overrun;
    logic              err_timeout;

    modport master (
        output frame_start, map_rdy, abort, thresh_valid,
        input  ram_rd_en, ram_rd_addr, radmap_rd_vld, clut_cpi,
               busy, frame_done, err_overrun, err_timeout
    );

    modport slave (
        input  frame_start, map_rdy, abort, thresh_valid,
        output ram_rd_en, ram_rd_addr, radmap_rd_vld, clut_cpi,
               busy, frame_done, err_overrun, err_timeout
    );
endinterface

// File: rtl/clut_vld_delay.sv
// rtl/clut_vld_delay.sv - fixed-depth shift register aligning read enable with RAM data
module clut_vld_delay #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);
    logic [DEPTH-1:0] sr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr <= '0;
        end else begin
            sr <= (sr << 1) | DEPTH'(din);
        end
    end

    assign dout = sr[DEPTH-1];
endmodule

// File: rtl/clut_thresh_ctrl.sv
// rtl/clut_thresh_ctrl.sv - clutter-map frame sequencer: gapless RAM sweep, beat drain, CPI counter
module clut_thresh_ctrl
    import clut_pkg::*;
#(
    parameter int LINE_LEN  = CLUT_LINE_LEN,
    parameter int NUM_LINES = 64,
    parameter int ADDR_W    = 11,
    parameter int RD_LAT    = 2,
    parameter int NUM_CPI   = CLUT_NUM_CPI,
    parameter int DRAIN_TMO = 1024
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    clut_thresh_ctrl_if.slave bus
);
    localparam int FRAME_BEATS = LINE_LEN * NUM_LINES;
    localparam int BEAT_W      = beat_w(LINE_LEN, NUM_LINES);
    localparam int BIN_W       = $clog2(LINE_LEN);
    localparam int LINE_W      = $clog2(NUM_LINES);
    localparam int TMO_W       = $clog2(DRAIN_TMO);

    clut_state_t       state, state_nxt;
    logic [BIN_W-1:0]  bin_cnt;
    logic [LINE_W-1:0] line_cnt;
    logic [BEAT_W-1:0] beat_cnt, beat_exp, beat_nxt, lines_beats;
    logic [TMO_W-1:0]  tmo_cnt;
    logic [15:0]       cpi;
    logic              abort_pend, err_ovr, err_tmo;
    logic              bin_last, frame_last, stop_read, drain_full, tmo_hit;
    logic              rd_en, rd_vld;

    assign bin_last    = (bin_cnt == BIN_W'(LINE_LEN - 1));
    assign frame_last  = bin_last && (line_cnt == LINE_W'(NUM_LINES - 1));
    // An abort in READ waits for the current line to finish so every row FIFO sees whole lines.
    assign stop_read   = bin_last && (abort_pend || bus.abort);
    assign lines_beats = BEAT_W'((int'(line_cnt) + 1) * LINE_LEN);
    assign beat_nxt    = beat_cnt + BEAT_W'(bus.thresh_valid);
    assign drain_full  = (beat_nxt >= beat_exp);
    assign tmo_hit     = (tmo_cnt == TMO_W'(DRAIN_TMO - 1));

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:     if (bus.frame_start) state_nxt = ST_WAIT_RDY;
            ST_WAIT_RDY: if (bus.abort) state_nxt = ST_IDLE;
                         else if (bus.map_rdy) state_nxt = ST_READ;
            ST_READ:     if (frame_last || stop_read) state_nxt = ST_DRAIN;
            // Completion (or forced close) takes priority over a simultaneous abort.
            ST_DRAIN:    if (drain_full || tmo_hit) state_nxt = ST_DONE;
                         else if (bus.abort) state_nxt = ST_IDLE;
            ST_DONE:     state_nxt = ST_IDLE;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            bin_cnt    <= '0;
            line_cnt   <= '0;
            beat_cnt   <= '0;
            beat_exp   <= '0;
            tmo_cnt    <= '0;
            abort_pend <= 1'b0;
            cpi        <= 16'd1;
            err_ovr    <= 1'b0;
            err_tmo    <= 1'b0;
        end else begin
            tmo_cnt <= (state == ST_DRAIN) ? tmo_cnt + TMO_W'(1) : '0;
            if (bus.frame_start && state != ST_IDLE) err_ovr <= 1'b1;
            if (state == ST_DRAIN && !drain_full && tmo_hit) err_tmo <= 1'b1;
            if (state == ST_DONE) cpi <= (cpi == 16'(NUM_CPI)) ? 16'd1 : cpi + 16'd1;

            if (state == ST_WAIT_RDY && state_nxt == ST_READ) begin
                bin_cnt    <= '0;
                line_cnt   <= '0;
                beat_cnt   <= '0;
                beat_exp   <= BEAT_W'(FRAME_BEATS);
                abort_pend <= 1'b0;
            end else if (state == ST_READ) begin
                bin_cnt  <= bin_last ? '0 : bin_cnt + BIN_W'(1);
                if (bin_last) line_cnt <= frame_last ? '0 : line_cnt + LINE_W'(1);
                if (bus.abort) abort_pend <= 1'b1;
                if (stop_read) beat_exp <= lines_beats;
                beat_cnt <= beat_nxt;
            end else if (state == ST_DRAIN) begin
                beat_cnt <= beat_nxt;
            end
        end
    end

    clut_vld_delay #(
        .DEPTH(RD_LAT)
    ) u_vld_delay (
        .clk  (sys_clk),
        .rst  (sys_rst),
        .din  (rd_en),
        .dout (rd_vld)
    );

    assign rd_en             = (state == ST_READ);
    assign bus.ram_rd_en     = rd_en;
    assign bus.ram_rd_addr   = rd_en ? ADDR_W'(int'(line_cnt) * LINE_LEN + int'(bin_cnt)) : '0;
    assign bus.radmap_rd_vld = rd_vld;
    assign bus.clut_cpi      = cpi;
    assign bus.busy          = (state != ST_IDLE);
    assign bus.frame_done    = (state == ST_DONE);
    assign bus.err_overrun   = err_ovr;
    assign bus.err_timeout   = err_tmo;
endmodule
